// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the MEM pipeline stage.
// Turns byte/half/word loads and stores (including LL/SC) into single
// transactions on a simple req/ack word bus with big-endian byte lanes.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   M_MemRead/M_MemWrite     load/store request from EXE/MEM
//   M_MemByte/M_MemHalf      access size (neither set = word)
//   M_MemSignExtend          sign-extend narrow loads
//   M_LLSC                   load-linked / store-conditional qualifier
//   M_ALU_Result, M_ReadData2  byte address, store data
//   ll_clear                 drops the link bit (eret/exception)
//   M_ReadData               registered load data or SC result
//   M_Stall, M_AddrErr       pipeline hold, misalignment flag
//   bus_*                    external word bus
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_MemRead,
  input  logic        M_MemWrite,
  input  logic        M_MemByte,
  input  logic        M_MemHalf,
  input  logic        M_MemSignExtend,
  input  logic        M_LLSC,
  input  logic [31:0] M_ALU_Result,
  input  logic [31:0] M_ReadData2,
  input  logic        ll_clear,
  output logic [31:0] M_ReadData,
  output logic        M_Stall,
  output logic        M_AddrErr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic [31:0] rd_data_r;
  logic        bus_req_r, bus_we_r;
  logic [29:0] bus_addr_r;
  logic [3:0]  bus_be_r;
  logic [31:0] bus_wdata_r;
  logic        link_r;
  logic [29:0] link_addr_r;
  // Attributes of the in-flight access, needed when the ack returns.
  logic        acc_load_r, acc_byte_r, acc_half_r, acc_sext_r, acc_ll_r, acc_sc_r;
  logic [1:0]  acc_off_r;

  logic        addr_err_s, access_s, sc_s, sc_ok_s, stall_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  // Big-endian lane enables: offset 0 selects bits 31:24.
  function automatic logic [3:0] lane_be(input logic is_byte, input logic is_half,
                                         input logic [1:0] off);
    logic [3:0] be;
    if (is_byte) begin
      case (off)
        2'd0:    be = 4'b1000;
        2'd1:    be = 4'b0100;
        2'd2:    be = 4'b0010;
        2'd3:    be = 4'b0001;
        default: be = 4'b0000;
      endcase
    end else if (is_half) begin
      be = off[1] ? 4'b0011 : 4'b1100;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Selects the addressed lane and right-justifies it with sign/zero fill.
  function automatic logic [31:0] load_fmt(input logic [31:0] rdata, input logic is_byte,
                                           input logic is_half, input logic sext,
                                           input logic [1:0] off);
    logic [7:0]  lb;
    logic [15:0] lh;
    logic [31:0] res;
    case (off)
      2'd0:    lb = rdata[31:24];
      2'd1:    lb = rdata[23:16];
      2'd2:    lb = rdata[15:8];
      2'd3:    lb = rdata[7:0];
      default: lb = 8'h00;
    endcase
    lh = off[1] ? rdata[15:0] : rdata[31:16];
    if (is_byte) begin
      res = {{24{sext & lb[7]}}, lb};
    end else if (is_half) begin
      res = {{16{sext & lh[15]}}, lh};
    end else begin
      res = rdata;
    end
    return res;
  endfunction

  assign addr_err_s = (M_MemRead | M_MemWrite) &
                      ((M_MemHalf & ~M_MemByte & M_ALU_Result[0]) |
                       (~M_MemHalf & ~M_MemByte & (M_ALU_Result[1:0] != 2'b00)));
  assign access_s   = (M_MemRead | M_MemWrite) & ~addr_err_s;
  assign sc_s       = M_MemWrite & M_LLSC;
  assign sc_ok_s    = link_r & (M_ALU_Result[31:2] == link_addr_r);
  assign be_s       = lane_be(M_MemByte, M_MemHalf, M_ALU_Result[1:0]);
  assign wdata_s    = M_MemByte ? {4{M_ReadData2[7:0]}} :
                      M_MemHalf ? {2{M_ReadData2[15:0]}} : M_ReadData2;

  // Next-state and stall decode; a failing SC skips the bus entirely.
  always_comb begin
    next_state_s = state_r;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          stall_s = 1'b1;
          if (sc_s & ~sc_ok_s) begin
            next_state_s = DONE;
          end else begin
            next_state_s = REQ;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        if (bus_ack) begin
          next_state_s = DONE;
        end else begin
          next_state_s = REQ;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Bus request registers, access attributes and load/SC result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 30'd0;
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'd0;
      rd_data_r   <= 32'd0;
      acc_load_r  <= 1'b0;
      acc_byte_r  <= 1'b0;
      acc_half_r  <= 1'b0;
      acc_sext_r  <= 1'b0;
      acc_ll_r    <= 1'b0;
      acc_sc_r    <= 1'b0;
      acc_off_r   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s && sc_s && !sc_ok_s) begin
            rd_data_r <= 32'd0;
          end else if (access_s) begin
            bus_req_r   <= 1'b1;
            bus_we_r    <= M_MemWrite;
            bus_addr_r  <= M_ALU_Result[31:2];
            bus_be_r    <= be_s;
            bus_wdata_r <= wdata_s;
            acc_load_r  <= M_MemRead & ~M_MemWrite;
            acc_byte_r  <= M_MemByte;
            acc_half_r  <= M_MemHalf;
            acc_sext_r  <= M_MemSignExtend;
            acc_ll_r    <= M_MemRead & M_LLSC;
            acc_sc_r    <= sc_s;
            acc_off_r   <= M_ALU_Result[1:0];
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req_r <= 1'b0;
            bus_we_r  <= 1'b0;
            if (acc_load_r) begin
              rd_data_r <= load_fmt(bus_rdata, acc_byte_r, acc_half_r, acc_sext_r, acc_off_r);
            end else if (acc_sc_r) begin
              rd_data_r <= 32'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Link bit: ll_clear overrides a completing LL; a successful SC consumes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_r      <= 1'b0;
      link_addr_r <= 30'd0;
    end else if (ll_clear) begin
      link_r <= 1'b0;
    end else if (state_r == REQ && bus_ack && acc_ll_r) begin
      link_r      <= 1'b1;
      link_addr_r <= bus_addr_r;
    end else if (state_r == REQ && bus_ack && acc_sc_r) begin
      link_r <= 1'b0;
    end
  end

  assign M_ReadData = rd_data_r;
  assign M_Stall    = stall_s;
  assign M_AddrErr  = addr_err_s;
  assign bus_req    = bus_req_r;
  assign bus_we     = bus_we_r;
  assign bus_addr   = bus_addr_r;
  assign bus_be     = bus_be_r;
  assign bus_wdata  = bus_wdata_r;

endmodule
